alu_seq: RTL and testbench

- Parametrised, handshaked successor to the processor's 8-bit ALU. Width is set by a parameter.
- Flags are registered: zero, negative, carry and overflow.
- Shifts are multi-bit and iterative, moving one bit per clock, so the block is multi-cycle. It accepts one operation at a time through a valid/ready handshake.
- Sits between the register file / immediate mux and the writeback stage. The CPU controller stalls on op_ready.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_shifter.sv | 59 +++++
 rtl/alu_seq.sv | 174 +++++++++++++++++
 tb/tb_alu_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 4-bit opcode encodings (OP_NOP .. OP_LOADIMM)
//   - control state encoding (ST_IDLE, ST_SHIFT)
//   - bit positions of the status flags when packed as {zero, negative, carry, overflow}
package alu_pkg;

    localparam logic [3:0] OP_NOP     = 4'b0000;
    localparam logic [3:0] OP_ADD     = 4'b0001;
    localparam logic [3:0] OP_SUB     = 4'b0010;
    localparam logic [3:0] OP_NAND    = 4'b0011;
    localparam logic [3:0] OP_SHL     = 4'b0100;
    localparam logic [3:0] OP_SHR     = 4'b0101;
    localparam logic [3:0] OP_OUT     = 4'b0110;
    localparam logic [3:0] OP_IN      = 4'b0111;
    localparam logic [3:0] OP_MOV     = 4'b1000;
    localparam logic [3:0] OP_BR      = 4'b1001;
    localparam logic [3:0] OP_BRC     = 4'b1010;
    localparam logic [3:0] OP_BRSUB   = 4'b1011;
    localparam logic [3:0] OP_RET     = 4'b1100;
    localparam logic [3:0] OP_LOAD    = 4'b1101;
    localparam logic [3:0] OP_STORE   = 4'b1110;
    localparam logic [3:0] OP_LOADIMM = 4'b1111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: iterative logical shifter, one bit per clock.
// Ports:
//   clock, reset    rising-edge clock, asynchronous active-high reset
//   load            capture value/amount/dir and start shifting (amount >= 1)
//   dir             0 = shift left, 1 = shift right
//   value, amount   operand and number of bit positions to move
//   busy            a shift is in progress
//   done            the coming edge performs the final shift step
//   shifted         working register after one more step (combinational)
//   last_out        bit that leaves the register on the coming edge
module alu_shifter #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               dir,
    input  logic [WIDTH-1:0]   value,
    input  logic [SHAMT_W-1:0] amount,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   shifted,
    output logic               last_out
);

    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] count;
    logic               dir_r;
    logic               busy_r;

    assign busy     = busy_r;
    // The owner commits 'shifted' and 'last_out' on the same edge that
    // the counter would reach zero, so the result lands at edge N+k.
    assign done     = busy_r && (count == SHAMT_W'(1));
    assign shifted  = dir_r ? {1'b0, work[WIDTH-1:1]} : {work[WIDTH-2:0], 1'b0};
    assign last_out = dir_r ? work[0] : work[WIDTH-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            work   <= '0;
            count  <= '0;
            dir_r  <= 1'b0;
            busy_r <= 1'b0;
        end else if (load) begin
            work   <= value;
            count  <= amount;
            dir_r  <= dir;
            busy_r <= (amount != '0);
        end else if (busy_r) begin
            work  <= shifted;
            count <= count - SHAMT_W'(1);
            if (done) begin
                busy_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked, parametrised ALU with registered result and flags.
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   op_valid / op_ready     request handshake; accept when both high at an edge
//   alu_op                  opcode (see alu_pkg)
//   operand_a, operand_b    operands; shamt is the shift distance for SHL/SHR
//   in_port                 external input port (IN)
//   result, result_valid    registered result and one-cycle completion pulse
//   zero, negative, carry, overflow   registered status flags
//   out_port, out_strobe    registered output port and its one-cycle write pulse
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [3:0]         alu_op,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   in_port,
    output logic [WIDTH-1:0]   result,
    output logic               result_valid,
    output logic               zero,
    output logic               negative,
    output logic               carry,
    output logic               overflow,
    output logic [WIDTH-1:0]   out_port,
    output logic               out_strobe
);

    state_t           state;
    logic             accept;
    logic             is_shift;
    logic             sh_load;
    logic             sh_busy;
    logic             sh_done;
    logic             sh_last;
    logic [WIDTH-1:0] sh_value;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] nand_r;

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    assign op_ready = (state == ST_IDLE);
    assign accept   = op_valid && op_ready;
    assign is_shift = (alu_op == OP_SHL) || (alu_op == OP_SHR);
    // A zero-distance shift completes in the idle cycle; the shifter is
    // only engaged for real multi-cycle work.
    assign sh_load  = accept && is_shift && (shamt != '0);

    // The extra top bit of diff is the borrow (a < b unsigned).
    assign sum    = {1'b0, operand_a} + {1'b0, operand_b};
    assign diff   = {1'b0, operand_a} - {1'b0, operand_b};
    assign nand_r = ~(operand_a & operand_b);

    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clock    (clock),
        .reset    (reset),
        .load     (sh_load),
        .dir      (alu_op == OP_SHR),
        .value    (operand_a),
        .amount   (shamt),
        .busy     (sh_busy),
        .done     (sh_done),
        .shifted  (sh_value),
        .last_out (sh_last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            result       <= '0;
            result_valid <= 1'b0;
            zero         <= 1'b0;
            negative     <= 1'b0;
            carry        <= 1'b0;
            overflow     <= 1'b0;
            out_port     <= '0;
            out_strobe   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            out_strobe   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (alu_op)
                            OP_ADD: begin
                                result       <= sum[WIDTH-1:0];
                                carry        <= sum[WIDTH];
                                overflow     <= add_ovf(operand_a, operand_b, sum[WIDTH-1:0]);
                                zero         <= (sum[WIDTH-1:0] == '0);
                                negative     <= sum[WIDTH-1];
                                result_valid <= 1'b1;
                            end
                            OP_SUB: begin
                                result       <= diff[WIDTH-1:0];
                                carry        <= diff[WIDTH];
                                overflow     <= sub_ovf(operand_a, operand_b, diff[WIDTH-1:0]);
                                zero         <= (diff[WIDTH-1:0] == '0);
                                negative     <= diff[WIDTH-1];
                                result_valid <= 1'b1;
                            end
                            OP_NAND: begin
                                result       <= nand_r;
                                zero         <= (nand_r == '0);
                                negative     <= nand_r[WIDTH-1];
                                result_valid <= 1'b1;
                            end
                            OP_SHL, OP_SHR: begin
                                if (shamt == '0) begin
                                    result       <= operand_a;
                                    zero         <= (operand_a == '0);
                                    negative     <= operand_a[WIDTH-1];
                                    result_valid <= 1'b1;
                                end else begin
                                    state <= ST_SHIFT;
                                end
                            end
                            OP_OUT: begin
                                out_port   <= operand_a;
                                out_strobe <= 1'b1;
                            end
                            OP_IN: begin
                                result       <= in_port;
                                result_valid <= 1'b1;
                            end
                            OP_MOV, OP_LOAD, OP_STORE, OP_LOADIMM: begin
                                result       <= operand_b;
                                result_valid <= 1'b1;
                            end
                            default: begin
                                // NOP and branch/return: accepted, no effect here
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    if (sh_done) begin
                        result       <= sh_value;
                        carry        <= sh_last;
                        zero         <= (sh_value == '0);
                        negative     <= sh_value[WIDTH-1];
                        result_valid <= 1'b1;
                        state        <= ST_IDLE;
                    end else if (!sh_busy) begin
                        // Shifter has nothing in flight; never wait forever.
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven bench with a result scoreboard for alu_seq (WIDTH=8).
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int SW = 3;

    logic          clock;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    alu_op;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic [SW-1:0] shamt;
    logic [W-1:0]  in_port;
    logic [W-1:0]  result;
    logic          result_valid;
    logic          zero, negative, carry, overflow;
    logic [W-1:0]  out_port;
    logic          out_strobe;

    alu_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clock        (clock),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .alu_op       (alu_op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .shamt        (shamt),
        .in_port      (in_port),
        .result       (result),
        .result_valid (result_valid),
        .zero         (zero),
        .negative     (negative),
        .carry        (carry),
        .overflow     (overflow),
        .out_port     (out_port),
        .out_strobe   (out_strobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // flags packed as {zero, negative, carry, overflow}
    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [SW-1:0] sh;
        logic [W-1:0] inp;
        logic [W-1:0] res;
        logic [3:0]   fl;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
        int           when;
    } sb_t;

    sb_t sb[$];

    // Scoreboard: every result_valid pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && result_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("sb_result", result, e.res);
                check("sb_flags", {zero, negative, carry, overflow}, e.fl);
                check("sb_latency", cyc, e.when);
            end
        end
    end

    // Drive one operation, hold op_valid until accepted, return the number of
    // cycles op_ready was seen low. Returns at the negedge after acceptance.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SW-1:0] sh, input logic [W-1:0] inp,
                         input bit push, input logic [W-1:0] res, input logic [3:0] fl,
                         output int waits);
        sb_t e;
        waits     = 0;
        alu_op    = op;
        operand_a = a;
        operand_b = b;
        shamt     = sh;
        in_port   = inp;
        op_valid  = 1'b1;
        while (!op_ready && waits < 40) begin
            @(negedge clock);
            waits++;
        end
        if (!op_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            op_valid = 1'b0;
            return;
        end
        if (push) begin
            e.res  = res;
            e.fl   = fl;
            e.when = cyc + 1 + (((op == OP_SHL) || (op == OP_SHR)) ? int'(sh) : 0);
            sb.push_back(e);
        end
        @(posedge clock);
        @(negedge clock);
        op_valid = 1'b0;
    endtask

    vec_t vecs[17];

    initial begin
        int waits;
        int prev_k;

        vecs[0]  = '{OP_ADD,     8'h7F, 8'h01, 3'd0, 8'h00, 8'h80, 4'b0101};
        vecs[1]  = '{OP_SUB,     8'h05, 8'h05, 3'd0, 8'h00, 8'h00, 4'b1000};
        vecs[2]  = '{OP_SUB,     8'h03, 8'h05, 3'd0, 8'h00, 8'hFE, 4'b0110};
        vecs[3]  = '{OP_NAND,    8'hF0, 8'hFF, 3'd0, 8'h00, 8'h0F, 4'b0010};
        vecs[4]  = '{OP_ADD,     8'hFF, 8'h01, 3'd0, 8'h00, 8'h00, 4'b1010};
        vecs[5]  = '{OP_ADD,     8'h80, 8'h80, 3'd0, 8'h00, 8'h00, 4'b1011};
        vecs[6]  = '{OP_IN,      8'h11, 8'h22, 3'd0, 8'h3C, 8'h3C, 4'b1011};
        vecs[7]  = '{OP_MOV,     8'h00, 8'h5A, 3'd0, 8'h00, 8'h5A, 4'b1011};
        vecs[8]  = '{OP_SUB,     8'h80, 8'h01, 3'd0, 8'h00, 8'h7F, 4'b0001};
        vecs[9]  = '{OP_SHL,     8'h81, 8'h00, 3'd3, 8'h00, 8'h08, 4'b0001};
        vecs[10] = '{OP_SHR,     8'h81, 8'h00, 3'd1, 8'h00, 8'h40, 4'b0011};
        vecs[11] = '{OP_SHL,     8'hC3, 8'h00, 3'd0, 8'h00, 8'hC3, 4'b0111};
        vecs[12] = '{OP_SHR,     8'h01, 8'h00, 3'd1, 8'h00, 8'h00, 4'b1011};
        vecs[13] = '{OP_NAND,    8'hFF, 8'hFF, 3'd0, 8'h00, 8'h00, 4'b1011};
        vecs[14] = '{OP_LOADIMM, 8'h00, 8'h99, 3'd0, 8'h00, 8'h99, 4'b1011};
        vecs[15] = '{OP_SHR,     8'h80, 8'h00, 3'd7, 8'h00, 8'h01, 4'b0001};
        vecs[16] = '{OP_SHL,     8'h01, 8'h00, 3'd7, 8'h00, 8'h80, 4'b0101};

        reset = 1'b1;
        op_valid = 1'b0;
        alu_op = OP_NOP;
        operand_a = '0;
        operand_b = '0;
        shamt = '0;
        in_port = '0;
        repeat (2) @(negedge clock);
        check("reset_result", result, 8'h00);
        check("reset_flags", {zero, negative, carry, overflow}, 4'b0000);
        check("reset_ready", op_ready, 1'b1);
        check("reset_outs", {result_valid, out_strobe, out_port}, 10'd0);
        reset = 1'b0;
        @(negedge clock);

        // Table: single-cycle ops and shifts, issued as fast as op_ready allows
        prev_k = 0;
        for (int i = 0; i < 17; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].inp,
                  1'b1, vecs[i].res, vecs[i].fl, waits);
            check($sformatf("ready_low_%0d", i), waits, prev_k);
            prev_k = ((vecs[i].op == OP_SHL) || (vecs[i].op == OP_SHR)) ? int'(vecs[i].sh) : 0;
        end
        repeat (8) @(negedge clock);

        // OUT: port written, strobe single pulse, result/flags untouched
        issue(OP_OUT, 8'hA5, 8'h00, 3'd0, 8'h00, 1'b0, 8'h00, 4'h0, waits);
        check("out_port", out_port, 8'hA5);
        check("out_strobe_hi", out_strobe, 1'b1);
        check("out_result_kept", result, 8'h80);
        check("out_flags_kept", {zero, negative, carry, overflow}, 4'b0101);
        @(negedge clock);
        check("out_strobe_lo", out_strobe, 1'b0);

        // Branch and NOP: accepted, nothing happens
        issue(OP_BR, 8'h12, 8'h34, 3'd0, 8'h00, 1'b0, 8'h00, 4'h0, waits);
        issue(OP_NOP, 8'h12, 8'h34, 3'd0, 8'h00, 1'b0, 8'h00, 4'h0, waits);
        repeat (3) @(negedge clock);
        check("br_result_kept", result, 8'h80);
        check("br_flags_kept", {zero, negative, carry, overflow}, 4'b0101);
        check("br_ready", op_ready, 1'b1);

        // ADD held valid during a 7-step shift; lands in the result_valid cycle
        issue(OP_SHL, 8'h03, 8'h00, 3'd7, 8'h00, 1'b1, 8'h80, 4'b0111, waits);
        issue(OP_ADD, 8'h40, 8'h40, 3'd0, 8'h00, 1'b1, 8'h80, 4'b0101, waits);
        check("held_add_wait", waits, 7);
        repeat (3) @(negedge clock);

        // Asynchronous reset in the middle of a 5-step shift
        issue(OP_SHL, 8'hFF, 8'h00, 3'd5, 8'h00, 1'b0, 8'h00, 4'h0, waits);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("midreset_result", result, 8'h00);
        check("midreset_flags", {zero, negative, carry, overflow}, 4'b0000);
        check("midreset_ready", op_ready, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("postreset_ready", op_ready, 1'b1);
        check("postreset_result", result, 8'h00);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
